// File: rtl/axil_reg_bridge_if.sv
// rtl/axil_reg_bridge_if.sv - AXI4-Lite bus bundle between interconnect (master) and bridge (slave)
// Parameters: ADDR_WIDTH, DATA_WIDTH (32 or 64); STRB_W = DATA_WIDTH/8.
// Channels: AW (AWADDR/AWPROT/AWVALID/AWREADY), W (WDATA/WSTRB/WVALID/WREADY),
//           B (BRESP/BVALID/BREADY), AR (ARADDR/ARPROT/ARVALID/ARREADY),
//           R (RDATA/RRESP/RVALID/RREADY).
interface axil_reg_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [2:0]            AWPROT;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic [STRB_W-1:0]     WSTRB;
    logic                  WVALID;
    logic                  WREADY;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [2:0]            ARPROT;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARPROT, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARPROT, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axil_reg_bridge.sv
// rtl/axil_reg_bridge.sv - AXI4-Lite slave that turns each transaction into one register-port request
// Ports: ACLK clock; ARESET synchronous active-high reset; axil = slave side of axil_reg_bridge_if;
//        reg_req/reg_we/reg_addr/reg_wdata/reg_wstrb out to the register bank,
//        reg_ack/reg_rdata/reg_err back from it.
// Optional feature: define AXIL_REG_BRIDGE_TIMEOUT_EN to add a reg_ack watchdog of TIMEOUT_CYCLES.
module axil_reg_bridge #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                    ADDR_SPAN      = 4096,
    parameter int                    TIMEOUT_CYCLES = 256
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    axil_reg_bridge_if.slave        axil,
    output logic                    reg_req,
    output logic                    reg_we,
    output logic [ADDR_WIDTH-1:0]   reg_addr,
    output logic [DATA_WIDTH-1:0]   reg_wdata,
    output logic [DATA_WIDTH/8-1:0] reg_wstrb,
    input  logic                    reg_ack,
    input  logic [DATA_WIDTH-1:0]   reg_rdata,
    input  logic                    reg_err
);
    localparam int                      STRB_W      = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]     BASE_EXT    = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0]     SPAN_EXT    = (ADDR_WIDTH+1)'(ADDR_SPAN);
    localparam logic [ADDR_WIDTH-1:0]   ALIGN_MASK  = ~ADDR_WIDTH'(STRB_W - 1);
    localparam logic [1:0]              RESP_OKAY   = 2'b00;
    localparam logic [1:0]              RESP_SLVERR = 2'b10;
    localparam logic [1:0]              RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, RESP} state_t;

    state_t                state;
    logic                  ready_en;
    logic                  aw_full, w_full, ar_full;
    logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]     w_strb;
    logic                  last_write;
    logic                  cur_write;
    logic                  bvalid_q, rvalid_q;
    logic [1:0]            resp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  wr_pend, rd_pend, pick_write, in_range;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [ADDR_WIDTH:0]   sel_diff;

`ifdef AXIL_REG_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wd_cnt;
`endif

    // Readies stay low through reset and rise on the first cycle after it.
    assign axil.AWREADY = ready_en && !aw_full;
    assign axil.WREADY  = ready_en && !w_full;
    assign axil.ARREADY = ready_en && !ar_full;
    assign axil.BVALID  = bvalid_q;
    assign axil.BRESP   = resp_q;
    assign axil.RVALID  = rvalid_q;
    assign axil.RRESP   = resp_q;
    assign axil.RDATA   = rdata_q;

    always_comb begin
        wr_pend    = aw_full && w_full;
        rd_pend    = ar_full;
        // On a tie the type not served last wins.
        pick_write = wr_pend && (!rd_pend || !last_write);
        sel_addr   = pick_write ? aw_addr : ar_addr;
        // One extra bit: an address below BASE_ADDR borrows into the MSB and
        // lands above any legal span, so the window can never wrap.
        sel_diff   = {1'b0, sel_addr} - BASE_EXT;
        in_range   = sel_diff < SPAN_EXT;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state      <= IDLE;
            ready_en   <= 1'b0;
            aw_full    <= 1'b0;
            w_full     <= 1'b0;
            ar_full    <= 1'b0;
            aw_addr    <= '0;
            ar_addr    <= '0;
            w_data     <= '0;
            w_strb     <= '0;
            last_write <= 1'b0;
            cur_write  <= 1'b0;
            bvalid_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            resp_q     <= RESP_OKAY;
            rdata_q    <= '0;
            reg_req    <= 1'b0;
            reg_we     <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            reg_wstrb  <= '0;
`ifdef AXIL_REG_BRIDGE_TIMEOUT_EN
            wd_cnt     <= '0;
`endif
        end else begin
            ready_en <= 1'b1;

            if (axil.AWVALID && axil.AWREADY) begin
                aw_full <= 1'b1;
                aw_addr <= axil.AWADDR;
            end
            if (axil.WVALID && axil.WREADY) begin
                w_full <= 1'b1;
                w_data <= axil.WDATA;
                w_strb <= axil.WSTRB;
            end
            if (axil.ARVALID && axil.ARREADY) begin
                ar_full <= 1'b1;
                ar_addr <= axil.ARADDR;
            end

            case (state)
                IDLE: begin
                    if (wr_pend || rd_pend) begin
                        cur_write  <= pick_write;
                        last_write <= pick_write;
                        if (in_range) begin
                            reg_req   <= 1'b1;
                            reg_we    <= pick_write;
                            reg_addr  <= sel_diff[ADDR_WIDTH-1:0] & ALIGN_MASK;
                            reg_wdata <= pick_write ? w_data : '0;
                            reg_wstrb <= pick_write ? w_strb : '0;
                            state     <= ISSUE;
`ifdef AXIL_REG_BRIDGE_TIMEOUT_EN
                            wd_cnt    <= '0;
`endif
                        end else begin
                            resp_q <= RESP_DECERR;
                            if (pick_write) begin
                                bvalid_q <= 1'b1;
                            end else begin
                                rvalid_q <= 1'b1;
                                rdata_q  <= '0;
                            end
                            state <= RESP;
                        end
                    end
                end

                // ISSUE is the cycle reg_req first shows; an ack there counts.
                ISSUE, WAIT_ACK: begin
                    if (reg_ack) begin
                        reg_req <= 1'b0;
                        resp_q  <= reg_err ? RESP_SLVERR : RESP_OKAY;
                        if (cur_write) begin
                            bvalid_q <= 1'b1;
                        end else begin
                            rvalid_q <= 1'b1;
                            rdata_q  <= reg_rdata;
                        end
                        state <= RESP;
`ifdef AXIL_REG_BRIDGE_TIMEOUT_EN
                    end else if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // reg_req has been up for TIMEOUT_CYCLES cycles: give up.
                        reg_req <= 1'b0;
                        resp_q  <= RESP_SLVERR;
                        if (cur_write) begin
                            bvalid_q <= 1'b1;
                        end else begin
                            rvalid_q <= 1'b1;
                            rdata_q  <= '0;
                        end
                        state <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                        state  <= WAIT_ACK;
`else
                    end else begin
                        state <= WAIT_ACK;
`endif
                    end
                end

                // Holding registers are released only on the response handshake,
                // which keeps a second AW back-pressured until the write completes.
                RESP: begin
                    if (bvalid_q && axil.BREADY) begin
                        bvalid_q <= 1'b0;
                        aw_full  <= 1'b0;
                        w_full   <= 1'b0;
                        state    <= IDLE;
                    end
                    if (rvalid_q && axil.RREADY) begin
                        rvalid_q <= 1'b0;
                        ar_full  <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_reg_bridge.sv
// tb/tb_axil_reg_bridge.sv - self-checking bench for axil_reg_bridge (window 0x1000..0x10FF)
module tb_axil_reg_bridge;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic        reg_req, reg_we, reg_ack, reg_err;
    logic [31:0] reg_addr, reg_wdata, reg_rdata;
    logic [3:0]  reg_wstrb;

    axil_reg_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axil_reg_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'h1000),
        .ADDR_SPAN(256), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .ACLK(clk), .ARESET(rst), .axil(bus),
        .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb), .reg_ack(reg_ack),
        .reg_rdata(reg_rdata), .reg_err(reg_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          wr;
        int          lead;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          dly;
        bit          err;
        logic [31:0] rdata;
        bit          exp_req;
        logic [31:0] exp_addr;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          hold;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit wr, input int lead, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] strb, input int dly,
                                input bit err, input logic [31:0] rdata, input bit exp_req,
                                input logic [31:0] exp_addr, input logic [1:0] exp_resp,
                                input logic [31:0] exp_rdata, input int exp_lat, input int hold);
        vec_t v;
        v.wr = wr; v.lead = lead; v.addr = addr; v.wdata = wdata; v.strb = strb;
        v.dly = dly; v.err = err; v.rdata = rdata; v.exp_req = exp_req;
        v.exp_addr = exp_addr; v.exp_resp = exp_resp; v.exp_rdata = exp_rdata;
        v.exp_lat = exp_lat; v.hold = hold;
        return v;
    endfunction

    task automatic clear_inputs();
        bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 1'b0;
        bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
        bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
        reg_ack = 1'b0; reg_rdata = '0; reg_err = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        chk("rst_awready", bus.AWREADY, 0);
        chk("rst_wready", bus.WREADY, 0);
        chk("rst_arready", bus.ARREADY, 0);
        chk("rst_bvalid", bus.BVALID, 0);
        chk("rst_rvalid", bus.RVALID, 0);
        chk("rst_bresp", bus.BRESP, 0);
        chk("rst_rdata", bus.RDATA, 0);
        chk("rst_reg_req", reg_req, 0);
        chk("rst_reg_addr", reg_addr, 0);
        chk("rst_reg_wstrb", reg_wstrb, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_awready", bus.AWREADY, 1);
        chk("post_rst_wready", bus.WREADY, 1);
        chk("post_rst_arready", bus.ARREADY, 1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int acc, req_c, t;
        bit seen, done, stable, early;
        logic [31:0] c_addr, c_wdata;
        logic [3:0]  c_strb;
        logic        c_we;
        string p;
        p = $sformatf("v%0d", idx);
        req_c = 0; c_addr = '0; c_wdata = '0; c_strb = '0; c_we = 1'b0;
        @(negedge clk);
        if (v.wr && v.lead > 0) begin
            bus.WDATA = v.wdata; bus.WSTRB = v.strb; bus.WVALID = 1'b1;
            t = 0;
            while (!bus.WREADY && t < 50) begin @(negedge clk); t++; end
            @(negedge clk);
            bus.WVALID = 1'b0;
            early = 1'b0;
            repeat (v.lead - 1) begin
                if (reg_req) early = 1'b1;
                @(negedge clk);
            end
            chk({p, "_early_req"}, early, 0);
            bus.AWADDR = v.addr; bus.AWVALID = 1'b1;
        end else if (v.wr) begin
            bus.AWADDR = v.addr; bus.AWVALID = 1'b1;
            bus.WDATA = v.wdata; bus.WSTRB = v.strb; bus.WVALID = 1'b1;
        end else begin
            bus.ARADDR = v.addr; bus.ARVALID = 1'b1;
        end
        t = 0;
        while (!(v.wr ? (bus.AWREADY && (bus.WREADY || !bus.WVALID)) : bus.ARREADY) && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({p, "_accept"}, t < 50, 1);
        acc = cyc;
        @(negedge clk);
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
        seen = 1'b0; done = 1'b0; t = 0;
        while (!done && t < 100) begin
            reg_ack = 1'b0;
            if (v.wr ? bus.BVALID : bus.RVALID) begin
                done = 1'b1;
            end else begin
                if (reg_req && !seen) begin
                    seen = 1'b1; req_c = cyc;
                    c_addr = reg_addr; c_wdata = reg_wdata; c_strb = reg_wstrb; c_we = reg_we;
                end
                if (seen && cyc == req_c + v.dly) begin
                    reg_ack = 1'b1; reg_rdata = v.rdata; reg_err = v.err;
                end
                @(negedge clk);
                t++;
            end
        end
        chk({p, "_resp_seen"}, done, 1);
        chk({p, "_req_issued"}, seen, v.exp_req);
        if (v.exp_req) begin
            chk({p, "_req_latency"}, req_c - acc, 2);
            chk({p, "_reg_addr"}, c_addr, v.exp_addr);
            chk({p, "_reg_we"}, c_we, v.wr);
            chk({p, "_reg_wstrb"}, c_strb, v.wr ? v.strb : 4'h0);
            if (v.wr) chk({p, "_reg_wdata"}, c_wdata, v.wdata);
        end
        chk({p, "_resp_latency"}, cyc - acc, v.exp_lat);
        chk({p, "_resp"}, v.wr ? bus.BRESP : bus.RRESP, v.exp_resp);
        if (!v.wr) chk({p, "_rdata"}, bus.RDATA, v.exp_rdata);
        stable = 1'b1;
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            if (!(bus.BVALID && bus.BRESP == v.exp_resp)) stable = 1'b0;
        end
        if (v.hold > 0) chk({p, "_resp_stable"}, stable, 1);
        bus.BREADY = v.wr; bus.RREADY = !v.wr;
        @(negedge clk);
        bus.BREADY = 1'b0; bus.RREADY = 1'b0;
        chk({p, "_valid_drop"}, v.wr ? bus.BVALID : bus.RVALID, 0);
        chk({p, "_req_low"}, reg_req, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, acc;
        bit ok;
        bit order[$];
        clear_inputs();

        vecs[0]  = mk(1, 0, 32'h1010, 32'hDEADBEEF, 4'hF, 1, 0, 32'h0,        1, 32'h10, 2'b00, 32'h0,        4, 0);
        vecs[1]  = mk(1, 5, 32'h1018, 32'h11223344, 4'hF, 1, 0, 32'h0,        1, 32'h18, 2'b00, 32'h0,        4, 0);
        vecs[2]  = mk(0, 0, 32'h1010, 32'h0,        4'h0, 1, 0, 32'hDEADBEEF, 1, 32'h10, 2'b00, 32'hDEADBEEF, 4, 0);
        vecs[3]  = mk(0, 0, 32'h1100, 32'h0,        4'h0, 0, 0, 32'h0,        0, 32'h0,  2'b11, 32'h0,        2, 0);
        vecs[4]  = mk(0, 0, 32'h10FC, 32'h0,        4'h0, 0, 0, 32'h12345678, 1, 32'hFC, 2'b00, 32'h12345678, 3, 0);
        vecs[5]  = mk(1, 0, 32'h1013, 32'h0000A5A5, 4'h3, 3, 0, 32'h0,        1, 32'h10, 2'b00, 32'h0,        6, 0);
        vecs[6]  = mk(1, 0, 32'h0FFC, 32'h1,        4'hF, 0, 0, 32'h0,        0, 32'h0,  2'b11, 32'h0,        2, 0);
        vecs[7]  = mk(1, 0, 32'h1020, 32'h0BADF00D, 4'hF, 1, 1, 32'h0,        1, 32'h20, 2'b10, 32'h0,        4, 10);
        vecs[8]  = mk(0, 0, 32'h1040, 32'h0,        4'h0, 1, 1, 32'hCAFEF00D, 1, 32'h40, 2'b10, 32'hCAFEF00D, 4, 0);
        vecs[9]  = mk(0, 0, 32'h1000, 32'h0,        4'h0, 2, 0, 32'h00000001, 1, 32'h0,  2'b00, 32'h1,        5, 0);
        vecs[10] = mk(0, 0, 32'hFFFFF000, 32'h0,    4'h0, 0, 0, 32'h0,        0, 32'h0,  2'b11, 32'h0,        2, 0);

        do_reset();
        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Reset while a read is waiting for its ack: request and pending work vanish.
        @(negedge clk);
        bus.ARADDR = 32'h1010; bus.ARVALID = 1'b1;
        @(negedge clk);
        bus.ARVALID = 1'b0;
        t = 0;
        while (!reg_req && t < 20) begin @(negedge clk); t++; end
        chk("abort_req_seen", reg_req, 1);
        do_reset();
        ok = 1'b1;
        repeat (5) begin
            if (reg_req || bus.RVALID) ok = 1'b0;
            @(negedge clk);
        end
        chk("abort_quiet", ok, 1);

        // AR and AW+W pending together twice; last-served starts as read.
        bus.BREADY = 1'b1; bus.RREADY = 1'b1;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            chk($sformatf("arb%0d_ready", r), bus.AWREADY && bus.WREADY && bus.ARREADY, 1);
            bus.AWADDR = 32'h1030; bus.AWVALID = 1'b1;
            bus.WDATA = 32'h100 + r; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
            bus.ARADDR = 32'h1034; bus.ARVALID = 1'b1;
            @(negedge clk);
            bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
            t = 0;
            while (order.size() < 2 * (r + 1) && t < 60) begin
                reg_ack = 1'b0;
                if (reg_req) begin
                    order.push_back(reg_we);
                    reg_ack = 1'b1; reg_rdata = 32'h0; reg_err = 1'b0;
                end
                @(negedge clk);
                t++;
            end
            reg_ack = 1'b0;
            repeat (4) @(negedge clk);
        end
        bus.BREADY = 1'b0; bus.RREADY = 1'b0;
        chk("arb_count", order.size(), 4);
        for (int i = 0; i < 4 && i < order.size(); i++)
            chk($sformatf("arb_order%0d", i), order[i], (i % 2 == 0) ? 1 : 0);

        // Register side never answers.
        @(negedge clk);
        bus.ARADDR = 32'h1044; bus.ARVALID = 1'b1;
        acc = cyc;
        @(negedge clk);
        bus.ARVALID = 1'b0;
`ifdef AXIL_REG_BRIDGE_TIMEOUT_EN
        t = 0;
        while (!bus.RVALID && t < 100) begin @(negedge clk); t++; end
        chk("tmo_latency", cyc - acc, 2 + TMO);
        chk("tmo_rresp", bus.RRESP, 2'b10);
        chk("tmo_rdata", bus.RDATA, 0);
        chk("tmo_req_drop", reg_req, 0);
        bus.RREADY = 1'b1;
        @(negedge clk);
        bus.RREADY = 1'b0;
        reg_ack = 1'b1; reg_rdata = 32'h77777777;
        @(negedge clk);
        reg_ack = 1'b0;
        ok = 1'b1;
        repeat (3) begin
            if (bus.RVALID || bus.BVALID || reg_req) ok = 1'b0;
            @(negedge clk);
        end
        chk("tmo_late_ack_ignored", ok, 1);
`else
        repeat (1000) @(negedge clk);
        chk("wait_req_held", reg_req, 1);
        chk("wait_no_rvalid", bus.RVALID, 0);
        reg_ack = 1'b1; reg_rdata = 32'h5A5A5A5A; reg_err = 1'b0;
        @(negedge clk);
        reg_ack = 1'b0;
        chk("wait_rvalid", bus.RVALID, 1);
        chk("wait_rdata", bus.RDATA, 32'h5A5A5A5A);
        bus.RREADY = 1'b1;
        @(negedge clk);
        bus.RREADY = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
